// File: rtl/uart_pkg.sv
// Shared types and packet-format helpers for the UART stream scheduler.
// Packet layout: sync, channel id, sample MSB, sample LSB, XOR of the first four.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int PKT_LEN = 5;

  localparam logic [2:0] IDX_SYNC = 3'd0;
  localparam logic [2:0] IDX_CH   = 3'd1;
  localparam logic [2:0] IDX_MSB  = 3'd2;
  localparam logic [2:0] IDX_LSB  = 3'd3;
  localparam logic [2:0] IDX_CSUM = 3'd4;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                          input logic [7:0]  sync,
                                          input logic [2:0]  ch,
                                          input logic [15:0] smp);
    logic [7:0] ch_byte;
    ch_byte = {5'b0, ch};
    case (idx)
      IDX_SYNC: pkt_byte = sync;
      IDX_CH:   pkt_byte = ch_byte;
      IDX_MSB:  pkt_byte = smp[15:8];
      IDX_LSB:  pkt_byte = smp[7:0];
      default:  pkt_byte = sync ^ ch_byte ^ smp[15:8] ^ smp[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester nearest after the last winner gets the grant.
// The pointer only moves when the caller accepts the grant via advance.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last;
  logic [PW-1:0] winner;
  logic [PW-1:0] idx;

  // Scan from lowest to highest priority so the nearest requester overwrites.
  always_comb begin
    grant  = '0;
    winner = last;
    idx    = '0;
    for (int i = N; i >= 1; i--) begin
      idx = PW'((int'(last) + i) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last <= PW'(N - 1);
    end else if (advance && (|req)) begin
      last <= winner;
    end
  end

endmodule

// File: rtl/uart_stream_scheduler.sv
// Grants beamformer channels round-robin and serialises each captured sample
// as a 5-byte packet through a START/BUSY handshaked UART transmitter.
module uart_stream_scheduler
  import uart_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 stop,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH*16-1:0] sample,
  output logic [NUM_CH-1:0]    grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 pkt_done,
  output logic                 pkt_abort,
  output logic                 active,
  output logic                 err_timeout
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  state_t            state, state_next;
  logic [2:0]        idx;
  logic [CW-1:0]     cnt;
  logic              stop_pend;
  logic [15:0]       smp_q;
  logic [2:0]        ch_q;
  logic              err_q;
  logic [NUM_CH-1:0] grant_q;
  logic              done_q;
  logic              abort_q;

  logic              take, retry, fin, drop, step;
  logic [NUM_CH-1:0] arb_grant;
  logic [15:0]       win_sample;
  logic [2:0]        win_ch;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .advance (take),
    .grant   (arb_grant)
  );

  always_comb begin
    win_sample = '0;
    win_ch     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (arb_grant[k]) begin
        win_sample = sample[16*k +: 16];
        win_ch     = 3'(k);
      end
    end
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    retry      = 1'b0;
    fin        = 1'b0;
    drop       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !stop && (|req)) begin
          take       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          retry      = 1'b1;
          state_next = SEND;
        end
      end
      WAIT_DONE: begin
        // The checksum byte always completes the packet, even with a stop pending.
        if (!tx_busy) begin
          if (idx == IDX_CSUM) begin
            fin        = 1'b1;
            state_next = IDLE;
          end else if (stop_pend || stop) begin
            drop       = 1'b1;
            state_next = IDLE;
          end else begin
            step       = 1'b1;
            state_next = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= IDX_SYNC;
      cnt       <= '0;
      stop_pend <= 1'b0;
      smp_q     <= '0;
      ch_q      <= '0;
      err_q     <= 1'b0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state   <= state_next;
      grant_q <= take ? arb_grant : '0;
      done_q  <= fin;
      abort_q <= drop;
      if (take) begin
        smp_q <= win_sample;
        ch_q  <= win_ch;
        idx   <= IDX_SYNC;
      end else if (step) begin
        idx <= idx + 3'd1;
      end
      if (state == SEND) begin
        cnt <= '0;
      end else if (state == WAIT_ACK && !tx_busy && !retry) begin
        cnt <= cnt + CW'(1);
      end
      if (retry) begin
        err_q <= 1'b1;
      end
      if (fin || drop) begin
        stop_pend <= 1'b0;
      end else if (stop && (state == SEND || state == WAIT_ACK)) begin
        stop_pend <= 1'b1;
      end
    end
  end

  assign grant       = grant_q;
  assign tx_start    = (state == SEND);
  assign active      = (state != IDLE);
  assign tx_data     = active ? pkt_byte(idx, SYNC_BYTE, ch_q, smp_q) : 8'h00;
  assign pkt_done    = done_q;
  assign pkt_abort   = abort_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_stream_scheduler.sv
// Scoreboard bench: grants push expected packet bytes, a monitor pops them on each
// TX_START; a simple transmitter model answers with a configurable BUSY pulse.
module tb_uart_stream_scheduler;

  localparam int NCH = 4;
  localparam int TMO = 16;

  logic            clock;
  logic            reset_n;
  logic            enable;
  logic            stop;
  logic [NCH-1:0]  req;
  logic [NCH*16-1:0] sample;
  logic [NCH-1:0]  grant;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            pkt_done;
  logic            pkt_abort;
  logic            active;
  logic            err_timeout;

  uart_stream_scheduler #(.NUM_CH(NCH), .SYNC_BYTE(8'hA5), .ACK_TIMEOUT(TMO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .stop        (stop),
    .req         (req),
    .sample      (sample),
    .grant       (grant),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .pkt_done    (pkt_done),
    .pkt_abort   (pkt_abort),
    .active      (active),
    .err_timeout (err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks, n_fail, cyc;
  logic [NCH-1:0]    req_prev;
  logic [NCH*16-1:0] sample_prev;
  logic              stop_prev, enable_prev;

  // reference model state
  bit         model_idle, have_cur, acked, stop_seen;
  int         last_ch, pkt_bytes, last_start_cyc, n_done, n_abort, n_start, exp_ch;
  logic [3:0] exp_g;
  logic [7:0] cur_byte;
  logic [7:0] exp_q[$];
  logic [7:0] byte_log[$];
  logic [3:0] grant_log[$];

  // transmitter model: rise_dly==0 means BUSY never rises
  int rise_dly, busy_len, wait_rise, busy_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    int c;
    for (int i = 1; i <= NCH; i++) begin
      c = (last + i) % NCH;
      if (((r >> c) & 4'b0001) != 4'b0000) return c;
    end
    return -1;
  endfunction

  task automatic push_pkt(input int ch, input logic [15:0] s);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'hA5; b1 = 8'(ch); b2 = s[15:8]; b3 = s[7:0];
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(b0 ^ b1 ^ b2 ^ b3);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_grant(output logic [3:0] g);
    bit hit;
    g = '0;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick();
      if (grant != '0) begin
        g = grant;
        hit = 1;
      end
    end
    if (!hit) check("grant_wait_expired", 0, 1);
  endtask

  task automatic wait_pkt_end();
    int base;
    bit hit;
    base = n_done + n_abort;
    hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      tick();
      if (n_done + n_abort != base) hit = 1;
    end
    if (!hit) check("pkt_end_wait_expired", 0, 1);
  endtask

  task automatic wait_bytes(input int n);
    bit hit;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick();
      if (pkt_bytes == n) hit = 1;
    end
    if (!hit) check("byte_wait_expired", 0, 1);
  endtask

  logic [3:0] g;
  logic [3:0] exp_order [5];
  logic [7:0] exp_bytes [5];
  int base, base2, base3;

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    reset_n = 1'b0; enable = 1'b0; stop = 1'b0; req = '0; sample = '0; tx_busy = 1'b0;
    rise_dly = 2; busy_len = 10; wait_rise = 0; busy_left = 0;
    model_idle = 1; last_ch = NCH - 1; have_cur = 0; acked = 0; stop_seen = 0;
    pkt_bytes = 0; last_start_cyc = 0; n_done = 0; n_abort = 0; n_start = 0;
    req_prev = '0; sample_prev = '0; stop_prev = 1'b0; enable_prev = 1'b0;

    fork
      begin : sampler
        forever begin
          @(posedge clock);
          cyc++;
          req_prev    = req;
          sample_prev = sample;
          stop_prev   = stop;
          enable_prev = enable;
        end
      end
      begin : monitor
        forever begin
          @(negedge clock);
          if (!reset_n) begin
            check("reset_outputs",
                  32'({grant, tx_start, tx_data, pkt_done, pkt_abort, active, err_timeout}), 0);
            model_idle = 1; last_ch = NCH - 1; exp_q.delete(); have_cur = 0; acked = 0;
            pkt_bytes = 0; stop_seen = 0;
            tx_busy = 1'b0; wait_rise = 0; busy_left = 0;
          end else begin
            exp_ch = (model_idle && enable_prev && !stop_prev) ? rr_pick(req_prev, last_ch) : -1;
            exp_g  = (exp_ch < 0) ? 4'b0000 : 4'(1 << exp_ch);
            if (grant != '0 || exp_ch >= 0) begin
              check("grant", grant, exp_g);
              grant_log.push_back(grant);
              if (exp_ch >= 0) begin
                last_ch = exp_ch;
                push_pkt(exp_ch, sample_prev[16*exp_ch +: 16]);
                model_idle = 0; pkt_bytes = 0; stop_seen = 0; have_cur = 0; acked = 0;
              end
            end
            if (!model_idle && stop_prev) stop_seen = 1;
            if (tx_start) begin
              n_start++;
              if (have_cur && !acked) begin
                check("retry_data", tx_data, cur_byte);
                check("retry_gap", cyc - last_start_cyc, TMO + 1);
              end else if (exp_q.size() == 0) begin
                check("unexpected_start", 1, 0);
              end else begin
                cur_byte = exp_q.pop_front();
                check("tx_byte", tx_data, cur_byte);
                byte_log.push_back(tx_data);
                pkt_bytes++;
                have_cur = 1;
              end
              acked = 0;
              last_start_cyc = cyc;
            end else if (active && have_cur) begin
              check("tx_data_hold", tx_data, cur_byte);
            end
            if (tx_busy) acked = 1;
            if (pkt_done) begin
              n_done++;
              check("done_len", pkt_bytes, PKT_LEN_TB());
              check("done_in_flight", model_idle, 0);
              model_idle = 1;
            end
            if (pkt_abort) begin
              n_abort++;
              check("abort_after_stop", stop_seen, 1);
              check("abort_before_last", (pkt_bytes < 5), 1);
              check("abort_byte_complete", acked, 1);
              exp_q.delete();
              model_idle = 1;
            end
            check("active", active, !model_idle);
            // transmitter model update happens after the DUT view is checked
            if (tx_start && rise_dly > 0) begin
              wait_rise = rise_dly;
            end else if (wait_rise > 0) begin
              wait_rise--;
              if (wait_rise == 0) begin
                tx_busy = 1'b1;
                busy_left = busy_len;
              end
            end else if (busy_left > 0) begin
              busy_left--;
              if (busy_left == 0) tx_busy = 1'b0;
            end
          end
        end
      end
      begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // single request, ch2 = 16'h1234
    exp_bytes = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h81};
    do_reset();
    enable = 1'b1;
    rise_dly = 2; busy_len = 10;
    sample[47:32] = 16'h1234;
    base = byte_log.size();
    base2 = grant_log.size();
    req = 4'b0100;
    wait_grant(g);
    req = '0;
    sample[47:32] = 16'hFFFF;
    check("t1_grant", g, 4'b0100);
    wait_pkt_end();
    check("t1_done_count", n_done, 1);
    check("t1_grants", grant_log.size() - base2, 1);
    for (int i = 0; i < 5; i++)
      check("t1_byte", (byte_log.size() > base + i) ? byte_log[base + i] : 8'hxx, exp_bytes[i]);
    tick();
    check("t1_active_after", active, 0);

    // round robin with re-asserted requests
    exp_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    rise_dly = 1; busy_len = 2;
    base2 = grant_log.size();
    for (int k = 0; k < NCH; k++) sample[16*k +: 16] = 16'($urandom);
    req = 4'b1011;
    for (int p = 0; p < 5; p++) begin
      wait_grant(g);
      req = req & ~g;
      for (int k = 0; k < NCH; k++) if (g[k]) sample[16*k +: 16] = 16'($urandom);
      tick();
      req = 4'b1011;
      wait_pkt_end();
    end
    req = '0;
    tick();
    for (int p = 0; p < 5; p++)
      check("t2_order", (grant_log.size() > base2 + p) ? grant_log[base2 + p] : 4'hx, exp_order[p]);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      tick();
      if (grant != '0) req = req & ~grant;
      for (int k = 0; k < NCH; k++) begin
        if (!req[k]) begin
          sample[16*k +: 16] = 16'($urandom);
          if ($urandom_range(0, 5) == 0) req[k] = 1'b1;
        end
      end
      enable   = ($urandom_range(0, 9) != 0);
      rise_dly = $urandom_range(1, 3);
      busy_len = $urandom_range(1, 4);
    end
    req = '0;
    enable = 1'b1;
    for (int i = 0; i < 300 && active; i++) tick();
    check("t3_drained", active, 0);
    check("t3_no_timeout", err_timeout, 0);

    // transmitter never answers: byte 0 retried forever
    rise_dly = 0;
    base2 = grant_log.size();
    base3 = n_start;
    req = 4'b0001;
    wait_grant(g);
    req = 4'b0010;
    repeat (5 * (TMO + 1) + 3) tick();
    check("t4_err_set", err_timeout, 1);
    check("t4_no_new_grant", grant_log.size() - base2, 1);
    check("t4_retries", (n_start - base3) >= 5, 1);
    repeat (20) tick();
    check("t4_err_sticky", err_timeout, 1);
    req = '0;
    do_reset();
    check("t4_err_cleared", err_timeout, 0);
    rise_dly = 3; busy_len = 3;

    // STOP pulse while byte 2 waits for its ack
    base = n_abort;
    base2 = n_done;
    req = 4'b0100;
    wait_grant(g);
    req = '0;
    wait_bytes(3);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_pkt_end();
    check("t5_abort", n_abort - base, 1);
    check("t5_no_done", n_done - base2, 0);
    check("t5_bytes_sent", pkt_bytes, 3);
    stop = 1'b1;
    req = 4'b0011;
    base2 = grant_log.size();
    base3 = n_start;
    repeat (30) tick();
    check("t5_stop_blocks_grant", grant_log.size() - base2, 0);
    check("t5_stop_blocks_start", n_start - base3, 0);
    stop = 1'b0;
    wait_grant(g);
    req = '0;
    wait_pkt_end();

    // reset during WAIT_DONE of byte 3, then channel 0 must win first
    rise_dly = 1; busy_len = 6;
    base = n_abort;
    req = 4'b0100;
    wait_grant(g);
    req = '0;
    wait_bytes(4);
    for (int i = 0; i < 20 && !tx_busy; i++) tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_reset",
          32'({grant, tx_start, tx_data, pkt_done, pkt_abort, active, err_timeout}), 0);
    tick();
    tick();
    reset_n = 1'b1;
    base3 = byte_log.size();
    req = 4'b1111;
    wait_grant(g);
    req = '0;
    check("t6_priority_ch0", g, 4'b0001);
    wait_pkt_end();
    check("t6_first_byte", (byte_log.size() > base3) ? byte_log[base3] : 8'hxx, 8'hA5);
    check("t6_no_abort", n_abort - base, 0);

    // STOP with REQ in IDLE; STOP during the checksum byte
    base2 = grant_log.size();
    stop = 1'b1;
    req = 4'b0010;
    repeat (10) tick();
    check("t7_stop_idle_no_grant", grant_log.size() - base2, 0);
    stop = 1'b0;
    wait_grant(g);
    req = '0;
    base = n_abort;
    base2 = n_done;
    wait_bytes(5);
    stop = 1'b1;
    wait_pkt_end();
    stop = 1'b0;
    check("t7_last_byte_done", n_done - base2, 1);
    check("t7_last_byte_no_abort", n_abort - base, 0);
    repeat (3) tick();
    check("t7_scoreboard_empty", exp_q.size(), 0);
    check("final_no_timeout", err_timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic int PKT_LEN_TB();
    return 5;
  endfunction

endmodule

// File: doc/uart_stream_scheduler.md
Name: uart_stream_scheduler

Overview:
- Sequences the UART transmitter so that beamformer output samples leave the FPGA as framed packets.
- Round-robin arbitrates NUM_CH sample requesters.
- Serialises each granted 16-bit sample into a 5-byte packet: sync, channel id, MSB, LSB, XOR checksum.
- Pulses the transmitter's START for each byte and paces on its BUSY flag. Sits between the beamformer channel outputs and the UART transmitter.

Parameters:
- NUM_CH, 4, number of requesters. Legal range 2..8.
- SYNC_BYTE, 8'hA5, first byte of every packet.
- ACK_TIMEOUT, 16, cycles to wait for TX_BUSY to rise after a START before the byte is retried.

Ports:
- CLOCK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  permits new grants.
- STOP  in  1  abort request; honoured at the next byte boundary.
- REQ  in  NUM_CH  per-channel sample valid; level, held until GRANT.
- SAMPLE  in  NUM_CH*16  packed samples; channel k occupies [16k+15:16k].
- GRANT  out  NUM_CH  one-hot, one-cycle pulse; sample captured.
- TX_START  out  1  start strobe to the transmitter.
- TX_DATA  out  8  byte to the transmitter.
- TX_BUSY  in  1  transmitter busy flag (registered copy from the transmitter).
- PKT_DONE  out  1  one-cycle pulse after the 5th byte completes.
- PKT_ABORT  out  1  one-cycle pulse when a packet is dropped by STOP.
- ACTIVE  out  1  high whenever state != IDLE.
- ERR_TIMEOUT  out  1  sticky; set on any ACK timeout, cleared only by reset.

Behaviour:
- Reset (asynchronous, RESET_N=0): state IDLE. All outputs 0, TX_DATA 8'h00. Byte index 0. RR pointer set so channel 0 has highest priority. Timeout counter 0, stop_pend 0. Reset mid-packet drops TX_START immediately; the packet is lost with no PKT_ABORT.
- States: IDLE, SEND, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If ENABLE=1, STOP=0 and REQ!=0, the winner is the first requester at or after (last_grant+1) mod NUM_CH.
  - On that edge: GRANT[winner]=1 for exactly one cycle; SAMPLE slice and channel id are registered; byte index=0; state -> SEND.
  - STOP=1 in IDLE blocks grants.
- SEND:
  - TX_START=1 for this single cycle.
  - TX_DATA = byte[index]. It stays stable until that byte leaves WAIT_DONE.
  - Timeout counter cleared. Next state WAIT_ACK.
- WAIT_ACK:
  - TX_BUSY=1 -> WAIT_DONE.
  - Otherwise the counter increments. When it reaches ACK_TIMEOUT-1: ERR_TIMEOUT<=1, state -> SEND, and the same byte is retried without limit.
- WAIT_DONE:
  - Waits for TX_BUSY=0.
  - Then, if index==4: PKT_DONE pulse, state -> IDLE.
  - Else, if stop_pend or STOP: PKT_ABORT pulse, stop_pend cleared, state -> IDLE.
  - Else: index+1, state -> SEND.
- Byte map:
  - 0 = SYNC_BYTE
  - 1 = {5'b0, ch[2:0]}
  - 2 = sample[15:8]
  - 3 = sample[7:0]
  - 4 = XOR of bytes 0..3
- STOP asserted in SEND or WAIT_ACK sets stop_pend. The abort happens only after the in-flight byte completes, so a byte is never truncated.
- STOP during the final byte still yields PKT_DONE, not PKT_ABORT.
- REQ changes after GRANT do not affect the captured sample.
- Minimum packet time: 5×(SEND + WAIT_ACK + WAIT_DONE) cycles.
- Back-to-back packets: after returning to IDLE, a new grant can occur on the very next edge.
- ENABLE falling mid-packet does not stop the current packet.
- Widths:
  - Timeout counter: $clog2(ACK_TIMEOUT) bits.
  - Byte index: 3 bits.
  - RR pointer: $clog2(NUM_CH) bits.
  - Pointer wraps NUM_CH-1 -> 0.

Decomposition:
- Shared package uart_pkg contains:
  - state enum (IDLE, SEND, WAIT_ACK, WAIT_DONE);
  - PKT_LEN=5;
  - byte index constants (IDX_SYNC, IDX_CH, IDX_MSB, IDX_LSB, IDX_CSUM);
  - default SYNC_BYTE.
- One sub-module, rr_arbiter (parameter N). Inputs: req, advance. Output: one-hot grant. It holds the last-grant pointer internally.

Test Plan:
- Single request, REQ=4'b0100, SAMPLE ch2=16'h1234, TX model raises BUSY 2 cycles after START for 10 cycles -> GRANT=4'b0100 one cycle; bytes A5,02,12,34,81; one PKT_DONE; ACTIVE low afterwards.
- REQ=4'b1011 held, re-asserted after each grant -> grant order ch0,ch1,ch3,ch0,ch1; each packet's byte 1 matches.
- TX model never raises BUSY -> TX_START pulses every ACK_TIMEOUT+1 cycles with TX_DATA=A5 held; ERR_TIMEOUT=1 stays set; no GRANT.
- STOP pulsed while byte 2 is in WAIT_ACK -> byte 2 completes; PKT_ABORT pulse; IDLE; no further TX_START while STOP held despite REQ!=0.
- RESET_N low during WAIT_DONE of byte 3 -> all outputs 0 asynchronously. After release with REQ=4'b0001, a new packet starts with A5 and channel 0 has priority.
- STOP and REQ rise in the same IDLE cycle -> no GRANT. STOP during byte 4 -> PKT_DONE and no PKT_ABORT.
